// File: rtl/usb_mem_port_arbiter.sv
// Shares one req/gnt data-memory port between a non-stallable USB posted-write stream and an AXI req/gnt port.
// One memory transaction outstanding at a time; USB writes are buffered in a small FIFO, AXI is stalled via axi_gnt_o.
module usb_mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                usb_wr_i,
    input  logic [ADDR_W-1:0]   usb_addr_i,
    input  logic [DATA_W-1:0]   usb_data_i,
    output logic                usb_full_o,
    output logic                usb_overflow_o,
    input  logic                usb_ovf_clr_i,
    input  logic                axi_req_i,
    input  logic                axi_we_i,
    input  logic [ADDR_W-1:0]   axi_addr_i,
    input  logic [DATA_W-1:0]   axi_wdata_i,
    input  logic [DATA_W/8-1:0] axi_be_i,
    output logic                axi_gnt_o,
    output logic                axi_rvalid_o,
    output logic [DATA_W-1:0]   axi_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic OWN_AXI = 1'b0;
    localparam logic OWN_USB = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_owner;

    logic [ADDR_W-1:0] q_addr [BUF_DEPTH];
    logic [DATA_W-1:0] q_data [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic q_empty;
    logic q_at_full;
    logic pop;
    logic push;
    logic drop;
    logic usb_pend;
    logic usb_sel;

    assign q_empty   = (count == '0);
    assign q_at_full = (count == FULL_CNT);

    // The entry being popped is the one already latched into mem_*, so a
    // same-cycle push into the freed slot is safe even when full.
    assign pop  = (state == ISSUE) && (owner == OWN_USB) && mem_gnt_i;
    assign push = usb_wr_i && (!q_at_full || pop);
    assign drop = usb_wr_i && q_at_full && !pop;

    assign usb_pend = !q_empty;
    assign usb_sel  = usb_pend && (!axi_req_i || usb_full_o || (last_owner == OWN_AXI));

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            usb_full_o     <= 1'b0;
            usb_overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_next;
            usb_full_o <= (count_next == FULL_CNT);
            if (drop) begin
                usb_overflow_o <= 1'b1;
            end else if (usb_ovf_clr_i) begin
                usb_overflow_o <= 1'b0;
            end
        end
    end

    // Queue storage needs no reset: occupancy alone defines validity.
    always_ff @(posedge Clk) begin
        if (push) begin
            q_addr[wr_ptr] <= usb_addr_i;
            q_data[wr_ptr] <= usb_data_i;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            owner       <= OWN_AXI;
            last_owner  <= OWN_AXI;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (usb_pend || axi_req_i) begin
                        state     <= ISSUE;
                        mem_req_o <= 1'b1;
                        if (usb_sel) begin
                            owner       <= OWN_USB;
                            last_owner  <= OWN_USB;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= q_addr[rd_ptr];
                            mem_wdata_o <= q_data[rd_ptr];
                            mem_be_o    <= {BE_W{1'b1}};
                        end else begin
                            owner       <= OWN_AXI;
                            last_owner  <= OWN_AXI;
                            mem_we_o    <= axi_we_i;
                            mem_addr_o  <= axi_addr_i;
                            mem_wdata_o <= axi_wdata_i;
                            mem_be_o    <= axi_be_i;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt_i) begin
                        state     <= WAIT_R;
                        mem_req_o <= 1'b0;
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

    assign axi_gnt_o    = (state == ISSUE) && (owner == OWN_AXI) && mem_gnt_i;
    assign axi_rvalid_o = (state == WAIT_R) && (owner == OWN_AXI) && mem_rvalid_i;
    assign axi_rdata_o  = axi_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_usb_mem_port_arbiter.sv
// Directed bench for usb_mem_port_arbiter: per-cycle vector table plus contention and reset sequences.
module tb_usb_mem_port_arbiter;

    localparam logic [31:0] AWD = 32'hCAFE_F00D;
    localparam logic [3:0]  ABE = 4'h3;

    logic        Clk;
    logic        Rst;
    logic        usb_wr_i;
    logic [31:0] usb_addr_i;
    logic [31:0] usb_data_i;
    logic        usb_full_o;
    logic        usb_overflow_o;
    logic        usb_ovf_clr_i;
    logic        axi_req_i;
    logic        axi_we_i;
    logic [31:0] axi_addr_i;
    logic [31:0] axi_wdata_i;
    logic [3:0]  axi_be_i;
    logic        axi_gnt_o;
    logic        axi_rvalid_o;
    logic [31:0] axi_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    usb_mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BUF_DEPTH(2)) dut (
        .Clk(Clk), .Rst(Rst),
        .usb_wr_i(usb_wr_i), .usb_addr_i(usb_addr_i), .usb_data_i(usb_data_i),
        .usb_full_o(usb_full_o), .usb_overflow_o(usb_overflow_o), .usb_ovf_clr_i(usb_ovf_clr_i),
        .axi_req_i(axi_req_i), .axi_we_i(axi_we_i), .axi_addr_i(axi_addr_i),
        .axi_wdata_i(axi_wdata_i), .axi_be_i(axi_be_i),
        .axi_gnt_o(axi_gnt_o), .axi_rvalid_o(axi_rvalid_o), .axi_rdata_o(axi_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        usb_wr;
        logic [31:0] usb_addr;
        logic [31:0] usb_data;
        logic        ovf_clr;
        logic        axi_req;
        logic        axi_we;
        logic [31:0] axi_addr;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        agnt;
        logic        arv;
        logic [31:0] ardata;
        logic        full;
        logic        ovf;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    int tests = 0;
    int fails = 0;

    function automatic in_t mk_in(input logic wr, input logic [31:0] ua, input logic [31:0] ud,
                                  input logic clr, input logic areq, input logic awe,
                                  input logic [31:0] aaddr, input logic g, input logic rv,
                                  input logic [31:0] rd);
        in_t v;
        v = '{wr, ua, ud, clr, areq, awe, aaddr, g, rv, rd};
        return v;
    endfunction

    function automatic out_t mk_out(input logic req, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    input logic agnt, input logic arv, input logic [31:0] ard,
                                    input logic full, input logic ovf);
        out_t v;
        v = '{req, we, addr, wdata, be, agnt, arv, ard, full, ovf};
        return v;
    endfunction

    function automatic out_t sample();
        return mk_out(mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
                      axi_gnt_o, axi_rvalid_o, axi_rdata_o, usb_full_o, usb_overflow_o);
    endfunction

    task automatic apply_in(input in_t v);
        usb_wr_i      = v.usb_wr;
        usb_addr_i    = v.usb_addr;
        usb_data_i    = v.usb_data;
        usb_ovf_clr_i = v.ovf_clr;
        axi_req_i     = v.axi_req;
        axi_we_i      = v.axi_we;
        axi_addr_i    = v.axi_addr;
        mem_gnt_i     = v.gnt;
        mem_rvalid_i  = v.rvalid;
        mem_rdata_i   = v.rdata;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        apply_in('0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
    endtask

    vec_t tbl [28];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t cur;
        int   grants;
        int   nusb;
        int   nfull;
        logic prev_gnt;
        logic prev_req;
        logic prev_full;
        logic is_usb;
        logic seen_req;

        axi_wdata_i = AWD;
        axi_be_i    = ABE;

        // idle + single USB write
        tbl[0]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{mk_in(1, 32'h0002_0040, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 1, 32'h0002_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0)};
        tbl[4]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111), mk_out(0, 1, 32'h0002_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0)};
        tbl[5]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 1, 32'h0002_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0)};
        tbl[6]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 1, 32'h0002_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0)};
        // AXI read, data two cycles after gnt
        tbl[7]  = '{mk_in(0, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0), mk_out(0, 1, 32'h0002_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0)};
        tbl[8]  = '{mk_in(0, 0, 0, 0, 1, 0, 32'h100, 1, 0, 0), mk_out(1, 0, 32'h100, AWD, ABE, 1, 0, 0, 0, 0)};
        tbl[9]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 32'h100, AWD, ABE, 0, 0, 0, 0, 0)};
        tbl[10] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678), mk_out(0, 0, 32'h100, AWD, ABE, 0, 1, 32'h1234_5678, 0, 0)};
        tbl[11] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678), mk_out(0, 0, 32'h100, AWD, ABE, 0, 0, 0, 0, 0)};
        // overflow with gnt held low, clear collides with a dropped write
        tbl[12] = '{mk_in(1, 32'h1000, 32'hA1, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 32'h100, AWD, ABE, 0, 0, 0, 0, 0)};
        tbl[13] = '{mk_in(1, 32'h1004, 32'hA2, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 32'h100, AWD, ABE, 0, 0, 0, 0, 0)};
        tbl[14] = '{mk_in(1, 32'h1008, 32'hA3, 0, 0, 0, 0, 0, 0, 0), mk_out(1, 1, 32'h1000, 32'hA1, 4'hF, 0, 0, 0, 1, 0)};
        tbl[15] = '{mk_in(1, 32'h100C, 32'hA4, 1, 0, 0, 0, 0, 0, 0), mk_out(1, 1, 32'h1000, 32'hA1, 4'hF, 0, 0, 0, 1, 1)};
        tbl[16] = '{mk_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), mk_out(1, 1, 32'h1000, 32'hA1, 4'hF, 0, 0, 0, 1, 1)};
        // push and pop together while full
        tbl[17] = '{mk_in(1, 32'h2000, 32'hB1, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 1, 32'h1000, 32'hA1, 4'hF, 0, 0, 0, 1, 0)};
        tbl[18] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mk_out(0, 1, 32'h1000, 32'hA1, 4'hF, 0, 0, 0, 1, 0)};
        tbl[19] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 1, 32'h1000, 32'hA1, 4'hF, 0, 0, 0, 1, 0)};
        tbl[20] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 1, 32'h1004, 32'hA2, 4'hF, 0, 0, 0, 1, 0)};
        tbl[21] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mk_out(0, 1, 32'h1004, 32'hA2, 4'hF, 0, 0, 0, 0, 0)};
        tbl[22] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 1, 32'h1004, 32'hA2, 4'hF, 0, 0, 0, 0, 0)};
        tbl[23] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 1, 32'h2000, 32'hB1, 4'hF, 0, 0, 0, 0, 0)};
        tbl[24] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mk_out(0, 1, 32'h2000, 32'hB1, 4'hF, 0, 0, 0, 0, 0)};
        tbl[25] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 1, 32'h2000, 32'hB1, 4'hF, 0, 0, 0, 0, 0)};
        tbl[26] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 1, 32'h2000, 32'hB1, 4'hF, 0, 0, 0, 0, 0)};
        tbl[27] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_5555), mk_out(0, 1, 32'h2000, 32'hB1, 4'hF, 0, 0, 0, 0, 0)};

        do_reset();
        for (int k = 0; k < 28; k++) begin
            @(negedge Clk);
            apply_in(tbl[k].i);
            #1;
            cur = sample();
            tests++;
            if (cur !== tbl[k].o) begin
                fails++;
                $display("FAIL vec%0d: got req=%b we=%b addr=%h wd=%h be=%h agnt=%b arv=%b ard=%h full=%b ovf=%b want req=%b we=%b addr=%h wd=%h be=%h agnt=%b arv=%b ard=%h full=%b ovf=%b",
                         k, cur.req, cur.we, cur.addr, cur.wdata, cur.be, cur.agnt, cur.arv, cur.ardata, cur.full, cur.ovf,
                         tbl[k].o.req, tbl[k].o.we, tbl[k].o.addr, tbl[k].o.wdata, tbl[k].o.be,
                         tbl[k].o.agnt, tbl[k].o.arv, tbl[k].o.ardata, tbl[k].o.full, tbl[k].o.ovf);
            end
        end

        // Contention: one USB entry always pending, AXI always requesting
        do_reset();
        usb_wr_i   = 1'b1;
        usb_addr_i = 32'h4000;
        usb_data_i = 32'h0;
        prev_gnt   = 1'b0;
        prev_req   = 1'b0;
        prev_full  = 1'b0;
        nusb       = 1;
        grants     = 0;
        for (int c = 0; c < 60 && grants < 8; c++) begin
            @(negedge Clk);
            axi_req_i    = 1'b1;
            axi_we_i     = 1'b1;
            axi_addr_i   = 32'h300;
            mem_gnt_i    = mem_req_o;
            mem_rvalid_i = prev_gnt;
            is_usb       = (mem_addr_o != 32'h300);
            usb_wr_i     = mem_req_o && is_usb;
            if (usb_wr_i) begin
                usb_addr_i = 32'h4000 + 32'(nusb * 4);
                nusb++;
            end
            #1;
            if (mem_req_o && mem_gnt_i) begin
                check($sformatf("tie_order%0d_is_usb", grants), 32'(is_usb), 32'(grants % 2 == 0));
                grants++;
            end
            prev_gnt  = mem_gnt_i;
            prev_req  = mem_req_o;
            prev_full = usb_full_o;
        end
        check("tie_grant_count", 32'(grants), 32'd8);

        // Contention with USB pushing every cycle: queue saturates
        nfull = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            usb_wr_i     = 1'b1;
            usb_addr_i   = 32'h4000 + 32'(nusb * 4);
            nusb++;
            mem_gnt_i    = mem_req_o;
            mem_rvalid_i = prev_gnt;
            is_usb       = (mem_addr_o != 32'h300);
            #1;
            if (mem_req_o && !prev_req && prev_full) begin
                check($sformatf("full_wins%0d_is_usb", nfull), 32'(is_usb), 32'd1);
                nfull++;
            end
            prev_gnt  = mem_gnt_i;
            prev_req  = mem_req_o;
            prev_full = usb_full_o;
        end
        check("full_grant_seen", 32'(nfull >= 3), 32'd1);

        // Reset while waiting for a USB response with one entry still queued
        do_reset();
        usb_wr_i   = 1'b1;
        usb_addr_i = 32'h5000;
        usb_data_i = 32'h51;
        @(negedge Clk);
        usb_addr_i = 32'h5004;
        usb_data_i = 32'h52;
        @(negedge Clk);
        usb_wr_i  = 1'b0;
        mem_gnt_i = 1'b1;
        #1;
        check("rst_setup_req", 32'(mem_req_o), 32'd1);
        check("rst_setup_addr", mem_addr_o, 32'h5000);
        @(negedge Clk);
        mem_gnt_i = 1'b0;
        #2;
        Rst = 1'b0;
        #1;
        cur = sample();
        tests++;
        if (cur !== '0) begin
            fails++;
            $display("FAIL rst_async_outputs: got %h want 0", cur);
        end
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_0BAD;
        #1;
        check("straggler_rvalid", 32'(axi_rvalid_o), 32'd0);
        check("straggler_rdata", axi_rdata_o, 32'd0);
        seen_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            mem_rvalid_i = 1'b0;
            #1;
            seen_req = seen_req | mem_req_o;
        end
        check("rst_queue_empty", 32'(seen_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_mem_port_arbiter.md
# usb_mem_port_arbiter

Shares the single PULPino-style data-memory port between two requesters. One is the USB-slave posted-write path: the FIFO drain logic that emits one-cycle write pulses and cannot be back-pressured. The other is the AXI-side request port, which uses a req/gnt handshake. The block buffers USB writes in a small posted-write queue, arbitrates round-robin with a starvation override, and keeps exactly one memory transaction outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- BUF_DEPTH, 2, USB posted-write queue depth; power of two, >= 2
- Clk  in  1  clock; all logic on the rising edge
- Rst  in  1  reset, asynchronous, active-low
- usb_wr_i  in  1  one-cycle USB write pulse
- usb_addr_i  in  ADDR_W  USB write address, valid with usb_wr_i
- usb_data_i  in  DATA_W  USB write data, valid with usb_wr_i
- usb_full_o  out  1  queue holds BUF_DEPTH entries
- usb_overflow_o  out  1  sticky flag: a USB write was dropped
- usb_ovf_clr_i  in  1  clears usb_overflow_o
- axi_req_i  in  1  AXI request; held with its attributes until axi_gnt_o
- axi_we_i  in  1  1 = write
- axi_addr_i  in  ADDR_W  AXI address
- axi_wdata_i  in  DATA_W  AXI write data
- axi_be_i  in  DATA_W/8  AXI byte enables
- axi_gnt_o  out  1  AXI request accepted by memory
- axi_rvalid_o  out  1  response for the AXI transaction
- axi_rdata_o  out  DATA_W  read data, valid with axi_rvalid_o
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory request
- mem_gnt_i  in  1  memory accepts the request
- mem_rvalid_i  in  1  memory response; one per granted transaction, in order
- mem_rdata_i  in  DATA_W  memory read data

## Operation
- USB queue: circular FIFO of {addr, data}.
  - Push on usb_wr_i when not full, or when full with a pop in the same cycle.
  - A push while full with no pop is dropped and sets usb_overflow_o. The queue is not modified.
  - usb_overflow_o clears on usb_ovf_clr_i. Set wins over clear in the same cycle.
- State machine:
  - IDLE -> ISSUE when the queue is non-empty or axi_req_i = 1. The selected request is registered into the mem_* outputs.
  - ISSUE holds mem_req_o = 1 with stable attributes until mem_gnt_i; then -> WAIT_R.
  - WAIT_R waits for mem_rvalid_i; then -> IDLE.
- Arbitration, evaluated in IDLE only:
  - Only one requester pending: it wins.
  - Both pending: USB wins if usb_full_o = 1. Otherwise the requester not granted last wins.
  - last_owner resets to AXI, so USB wins the first tie.
- USB transactions: mem_we_o = 1, mem_be_o all ones. The queue pops in the cycle mem_gnt_i is high in ISSUE.
- AXI transactions:
  - axi_gnt_o = mem_gnt_i while in ISSUE with owner AXI (combinational).
  - axi_rvalid_o = mem_rvalid_i while in WAIT_R with owner AXI.
  - axi_rdata_o = mem_rdata_i when axi_rvalid_o = 1, otherwise 0.
- mem_rvalid_i arriving in IDLE or ISSUE is ignored (post-reset stragglers).

## Timing
- Reset values: all outputs 0, queue empty, state IDLE, last_owner = AXI, usb_overflow_o = 0.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; mem_req_o drops asynchronously.
  - Queued USB writes are discarded.
- Latency, request pending in IDLE at cycle N:
  - mem_req_o high at N+1.
  - With gnt at N+1 and rvalid at N+2, the block is back in IDLE at N+3.
  - The next request is issued at N+4.
- Queue:
  - Push visible to arbitration in the cycle after usb_wr_i.
  - usb_full_o is registered from occupancy and updates the cycle after a push or pop.
- Pointers wrap modulo BUF_DEPTH.
- Occupancy counter has $clog2(BUF_DEPTH)+1 bits and never exceeds BUF_DEPTH.
- mem_* attributes change only on the IDLE->ISSUE edge.

## Test plan
- Single USB write: usb_wr_i with addr 0x0002_0040 and data 0xDEADBEEF; gnt and rvalid given immediately. Required: one mem write with be 4'hF, axi_gnt_o never high, queue empty at the end.
- AXI read: axi_req_i with we = 0 and addr 0x100; memory returns 0x1234_5678 two cycles after gnt. Required: axi_gnt_o pulses once, axi_rvalid_o high for one cycle, axi_rdata_o = 0x12345678.
- Contention: AXI and USB requests held continuously with BUF_DEPTH = 2. Required: grants alternate USB, AXI, USB, ... on ties, and USB is always granted when usb_full_o = 1.
- Overflow: mem_gnt_i held low, three USB pulses. Required: first two are queued, third is dropped, usb_overflow_o = 1. Pulse usb_ovf_clr_i together with a fourth write. Required: usb_overflow_o stays 1.
- Simultaneous push and pop: queue full; usb_wr_i in the same cycle as mem_gnt_i for USB. Required: write accepted, no overflow, usb_full_o stays 1.
- Reset mid-operation: Rst low while in WAIT_R with one USB entry queued. Required: all outputs 0 immediately. A mem_rvalid_i after reset release does not produce axi_rvalid_o, and the queue is empty.
